// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with saturating direction counters looked up
// at fetch, plus EX-stage branch/jump resolution. Optional stats via BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic              res_is_jump,
  input  logic [DATA_W-1:0] res_pc,
  input  logic [DATA_W-1:0] res_imm,
  input  logic [2:0]        res_func3,
  input  logic [DATA_W-1:0] res_rs1,
  input  logic [DATA_W-1:0] res_rs2,
  input  logic              res_pred_taken,
  input  logic              btb_flush,
  output logic              mispredict,
  output logic [DATA_W-1:0] recover_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_WT - CNT_W'(1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [DATA_W-1:0]  target_q [ENTRIES];
  logic [DATA_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx       = fetch_pc[IDX_W+1:2];
  assign f_tag       = fetch_pc[DATA_W-1:IDX_W+2];
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && cnt_q[f_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + DATA_W'(PC_STEP);

  // Resolve-side condition evaluation
  logic              res_legal;
  logic              cond;
  logic              actual_taken;
  logic [DATA_W-1:0] res_target;
  logic [DATA_W-1:0] res_fall;

  always_comb begin
    res_legal = res_is_jump || (res_func3[2:1] != 2'b01);
    case (res_func3)
      3'b000:  cond = (res_rs1 == res_rs2);
      3'b001:  cond = (res_rs1 != res_rs2);
      3'b100:  cond = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  cond = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  cond = (res_rs1 <  res_rs2);
      3'b111:  cond = (res_rs1 >= res_rs2);
      default: cond = 1'b0;
    endcase
    actual_taken = res_is_jump || cond;
  end

  assign res_target = res_pc + res_imm;
  assign res_fall   = res_pc + DATA_W'(PC_STEP);
  assign mispredict = res_valid && res_legal && (actual_taken != res_pred_taken);
  assign recover_pc = actual_taken ? res_target : res_fall;

  // Table update
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;

  assign r_idx   = res_pc[IDX_W+1:2];
  assign r_tag   = res_pc[DATA_W-1:IDX_W+2];
  assign r_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign cnt_inc = (cnt_q[r_idx] == CNT_MAX) ? CNT_MAX : cnt_q[r_idx] + CNT_W'(1);
  assign cnt_dec = (cnt_q[r_idx] == '0) ? '0 : cnt_q[r_idx] - CNT_W'(1);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (btb_flush) begin
      valid_d = '0;
    end else if (res_valid && res_legal) begin
      if (r_hit) begin
        if (res_is_jump) begin
          cnt_d[r_idx] = CNT_MAX;
        end else begin
          cnt_d[r_idx]    = actual_taken ? cnt_inc : cnt_dec;
          target_d[r_idx] = res_target;
        end
      end else if (actual_taken) begin
        // Allocation overwrites whatever alias occupied this slot
        valid_d[r_idx]  = 1'b1;
        tag_d[r_idx]    = r_tag;
        target_d[r_idx] = res_target;
        cnt_d[r_idx]    = res_is_jump ? CNT_MAX : CNT_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  // Counters reset to weakly not-taken so a fresh allocation starts one step above
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst) cnt_q[gi] <= CNT_RST;
        else     cnt_q[gi] <= cnt_d[gi];
      end
    end
  endgenerate

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (res_valid && res_legal && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != '1))             stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], res_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed test-plan scenarios followed
// by randomized traffic against a behavioural BTB model.
module tb_branch_predict_unit;
  localparam int DATA_W  = 64;
  localparam int ENTRIES = 16;
  localparam int PC_STEP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] fetch_pc = '0;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_target;
  logic              res_valid = 1'b0;
  logic              res_is_jump = 1'b0;
  logic [DATA_W-1:0] res_pc = '0;
  logic [DATA_W-1:0] res_imm = '0;
  logic [2:0]        res_func3 = '0;
  logic [DATA_W-1:0] res_rs1 = '0;
  logic [DATA_W-1:0] res_rs2 = '0;
  logic              res_pred_taken = 1'b0;
  logic              btb_flush = 1'b0;
  logic              mispredict;
  logic [DATA_W-1:0] recover_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.DATA_W(DATA_W), .ENTRIES(ENTRIES), .CNT_W(2), .PC_STEP(PC_STEP)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .res_valid(res_valid), .res_is_jump(res_is_jump),
    .res_pc(res_pc), .res_imm(res_imm), .res_func3(res_func3), .res_rs1(res_rs1),
    .res_rs2(res_rs2), .res_pred_taken(res_pred_taken), .btb_flush(btb_flush),
    .mispredict(mispredict), .recover_pc(recover_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Behavioural model: per-slot entry holding the full upper PC bits and an integer counter
  bit          m_v   [ENTRIES];
  logic [63:0] m_tag [ENTRIES];
  logic [63:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  longint      m_br = 0;
  longint      m_mp = 0;

  function automatic int m_idx(logic [63:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_legal(bit j, logic [2:0] f);
    return j || (f != 3'd2 && f != 3'd3);
  endfunction

  function automatic bit m_taken(bit j, logic [2:0] f, logic [63:0] a, logic [63:0] b);
    if (j) return 1'b1;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_hit(logic [63:0] pc);
    return m_v[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> 6));
  endfunction

  function automatic bit m_pred(logic [63:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [63:0] m_ptgt(logic [63:0] pc);
    return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 64'(PC_STEP);
  endfunction

  task automatic model_commit();
    bit lg, tk;
    int ix;
    lg = m_legal(res_is_jump, res_func3);
    tk = m_taken(res_is_jump, res_func3, res_rs1, res_rs2);
    ix = m_idx(res_pc);
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_v[i] = 1'b0;
        m_cnt[i] = 1;
      end
      m_br = 0;
      m_mp = 0;
    end else begin
      if (res_valid && lg && m_br < 64'hFFFF_FFFF) m_br++;
      if (res_valid && lg && tk != res_pred_taken && m_mp < 64'hFFFF_FFFF) m_mp++;
      if (btb_flush) begin
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
      end else if (res_valid && lg) begin
        if (m_hit(res_pc)) begin
          if (res_is_jump) m_cnt[ix] = 3;
          else begin
            m_cnt[ix] = tk ? ((m_cnt[ix] + 1 > 3) ? 3 : m_cnt[ix] + 1)
                           : ((m_cnt[ix] - 1 < 0) ? 0 : m_cnt[ix] - 1);
            m_tgt[ix] = res_pc + res_imm;
          end
        end else if (tk) begin
          m_v[ix]   = 1'b1;
          m_tag[ix] = res_pc >> 6;
          m_tgt[ix] = res_pc + res_imm;
          m_cnt[ix] = res_is_jump ? 3 : 2;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0;
    btb_flush = 1'b0;
    res_valid = 1'b0;
    res_is_jump = 1'b0;
    res_pred_taken = 1'b0;
  endtask

  task automatic set_res(bit j, logic [63:0] pc, logic [63:0] imm, logic [2:0] f,
                         logic [63:0] a, logic [63:0] b, bit pr);
    res_valid = 1'b1;
    res_is_jump = j;
    res_pc = pc;
    res_imm = imm;
    res_func3 = f;
    res_rs1 = a;
    res_rs2 = b;
    res_pred_taken = pr;
  endtask

  task automatic test_reset();
    logic [63:0] pcs [3];
    pcs[0] = 64'h100; pcs[1] = 64'h0; pcs[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    rst = 1'b1;
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL reset_pred_taken pc=%h got=%b exp=0", pcs[i], pred_taken);
      end
      checks++;
      if (pred_target !== pcs[i] + 64'd4) begin
        failures++;
        $display("FAIL reset_pred_target pc=%h got=%h exp=%h", pcs[i], pred_target, pcs[i] + 64'd4);
      end
      $display("reset lookup pc=%h taken=%b target=%h", pcs[i], pred_taken, pred_target);
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
`endif
  endtask

  task automatic test_counter();
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
    bit prs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit exp_mp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] exp_rpc [5] = '{64'h140, 64'h104, 64'h104, 64'h104, 64'h140};
    bit exp_pt [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] exp_tgt [5] = '{64'h140, 64'h104, 64'h104, 64'h104, 64'h104};
    fetch_pc = 64'h100;
    for (int i = 0; i < 5; i++) begin
      set_res(1'b0, 64'h100, 64'h40, f3s[i], 64'd5, 64'd5, prs[i]);
      #1;
      checks++;
      if (mispredict !== exp_mp[i] || recover_pc !== exp_rpc[i]) begin
        failures++;
        $display("FAIL counter_resolve step=%0d got=%b/%h exp=%b/%h", i, mispredict, recover_pc, exp_mp[i], exp_rpc[i]);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (pred_taken !== exp_pt[i] || pred_target !== exp_tgt[i]) begin
        failures++;
        $display("FAIL counter_lookup step=%0d got=%b/%h exp=%b/%h", i, pred_taken, pred_target, exp_pt[i], exp_tgt[i]);
      end
      $display("counter step=%0d f3=%0d mp=%b rpc=%h next_taken=%b", i, f3s[i], exp_mp[i], exp_rpc[i], pred_taken);
    end
  endtask

  task automatic test_compare();
    set_res(1'b0, 64'h208, 64'h20, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    #1;
    checks++;
    if (mispredict !== 1'b1 || recover_pc !== 64'h228) begin
      failures++;
      $display("FAIL blt_signed got=%b/%h exp=1/228", mispredict, recover_pc);
    end
    $display("BLT -1<1 mp=%b rpc=%h", mispredict, recover_pc);
    tick();
    set_res(1'b0, 64'h30C, 64'h20, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    #1;
    checks++;
    if (mispredict !== 1'b0 || recover_pc !== 64'h310) begin
      failures++;
      $display("FAIL bltu_unsigned got=%b/%h exp=0/310", mispredict, recover_pc);
    end
    $display("BLTU max<1 mp=%b rpc=%h", mispredict, recover_pc);
    tick();
    set_res(1'b0, 64'h410, 64'h20, 3'd2, 64'd5, 64'd5, 1'b1);
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      failures++;
      $display("FAIL illegal_func3 got=%b exp=0", mispredict);
    end
    $display("func3=010 mp=%b", mispredict);
    tick();
    set_idle();
    fetch_pc = 64'h410;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h414) begin
      failures++;
      $display("FAIL illegal_no_alloc got=%b/%h exp=0/414", pred_taken, pred_target);
    end
    fetch_pc = 64'h208;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h228) begin
      failures++;
      $display("FAIL blt_alloc got=%b/%h exp=1/228", pred_taken, pred_target);
    end
    fetch_pc = 64'h30C;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL bltu_no_alloc got=%b exp=0", pred_taken);
    end
  endtask

  task automatic test_alias();
    rst = 1'b1;
    tick();
    set_idle();
    set_res(1'b0, 64'h100, 64'h40, 3'd0, 64'd7, 64'd7, 1'b0);
    tick();
    set_res(1'b0, 64'h140, 64'h80, 3'd0, 64'd7, 64'd7, 1'b0);
    tick();
    set_idle();
    fetch_pc = 64'h140;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h1C0) begin
      failures++;
      $display("FAIL alias_new got=%b/%h exp=1/1c0", pred_taken, pred_target);
    end
    fetch_pc = 64'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h104) begin
      failures++;
      $display("FAIL alias_evicted got=%b/%h exp=0/104", pred_taken, pred_target);
    end
    $display("alias 0x140 replaced 0x100 in slot 0");
  endtask

  task automatic test_same_cycle();
    fetch_pc = 64'h100;
    set_res(1'b0, 64'h100, 64'h40, 3'd0, 64'd1, 64'd1, 1'b0);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h104) begin
      failures++;
      $display("FAIL same_cycle_alloc got=%b/%h exp=0/104", pred_taken, pred_target);
    end
    tick();
    set_res(1'b0, 64'h100, 64'h40, 3'd1, 64'd1, 64'd1, 1'b1);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h140) begin
      failures++;
      $display("FAIL same_cycle_old got=%b/%h exp=1/140", pred_taken, pred_target);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_after got=%b exp=0", pred_taken);
    end
    $display("same-cycle lookup returned pre-update state");
  endtask

  task automatic test_flush();
    logic [63:0] pcs [3];
    pcs[0] = 64'h520; pcs[1] = 64'h100; pcs[2] = 64'h7C4;
    set_res(1'b1, 64'h520, 64'h100, 3'd2, 64'd0, 64'd0, 1'b0);
    #1;
    checks++;
    if (mispredict !== 1'b1 || recover_pc !== 64'h620) begin
      failures++;
      $display("FAIL jump_resolve got=%b/%h exp=1/620", mispredict, recover_pc);
    end
    tick();
    set_res(1'b0, 64'h100, 64'h40, 3'd0, 64'd3, 64'd3, 1'b0);
    fetch_pc = 64'h520;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h620) begin
      failures++;
      $display("FAIL jump_alloc got=%b/%h exp=1/620", pred_taken, pred_target);
    end
    tick();
    set_res(1'b0, 64'h7C4, 64'h10, 3'd0, 64'd3, 64'd3, 1'b0);
    btb_flush = 1'b1;
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("FAIL flush_mispredict got=%b exp=1", mispredict);
    end
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      #1;
      checks++;
      if (pred_taken !== 1'b0 || pred_target !== pcs[i] + 64'd4) begin
        failures++;
        $display("FAIL flush_miss pc=%h got=%b/%h exp=0/%h", pcs[i], pred_taken, pred_target, pcs[i] + 64'd4);
      end
    end
    $display("flush cleared all entries");
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mp)) begin
      failures++;
      $display("FAIL flush_stats got=%0d/%0d exp=%0d/%0d", stat_branches, stat_mispredicts, m_br, m_mp);
    end
`endif
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = 64'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
    if ($urandom_range(0, 7) == 0) p = p | 64'hFFFF_FFFF_0000_0000;
    return p;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'd5;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    int r;
    int s;
    bit e_pt, e_mp, lg, tk;
    logic [63:0] e_tgt, e_rpc;
    rst = 1'b1;
    tick();
    set_idle();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      btb_flush = (r >= 1 && r <= 3);
      s = int'($urandom_range(0, 255)) - 128;
      set_res($urandom_range(0, 7) == 0, rand_pc(), 64'(longint'(s) * 4),
              3'($urandom_range(0, 7)), rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      res_valid = ($urandom_range(0, 9) < 7);
      fetch_pc = ($urandom_range(0, 1) == 1) ? res_pc : rand_pc();
      #1;
      e_pt  = m_pred(fetch_pc);
      e_tgt = m_ptgt(fetch_pc);
      lg    = m_legal(res_is_jump, res_func3);
      tk    = m_taken(res_is_jump, res_func3, res_rs1, res_rs2);
      e_mp  = res_valid && lg && (tk != res_pred_taken);
      e_rpc = tk ? res_pc + res_imm : res_pc + 64'(PC_STEP);
      checks++;
      if (pred_taken !== e_pt || pred_target !== e_tgt) begin
        failures++;
        $display("FAIL rand_lookup n=%0d pc=%h got=%b/%h exp=%b/%h", n, fetch_pc, pred_taken, pred_target, e_pt, e_tgt);
      end
      checks++;
      if (mispredict !== e_mp || (res_valid && recover_pc !== e_rpc)) begin
        failures++;
        $display("FAIL rand_resolve n=%0d pc=%h f3=%0d j=%b got=%b/%h exp=%b/%h", n, res_pc, res_func3, res_is_jump, mispredict, recover_pc, e_mp, e_rpc);
      end
      $display("rand n=%0d fetch=%h taken=%b v=%b pc=%h f3=%0d j=%b mp=%b", n, fetch_pc, e_pt, res_valid, res_pc, res_func3, res_is_jump, e_mp);
      tick();
    end
    set_idle();
`ifdef BRANCH_STATS_EN
    #1;
    checks++;
    if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mp)) begin
      failures++;
      $display("FAIL rand_stats got=%0d/%0d exp=%0d/%0d", stat_branches, stat_mispredicts, m_br, m_mp);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_counter();
    test_compare();
    test_alias();
    test_same_cycle();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
